// File: rtl/can_reg_arbiter.sv
// Round-robin arbiter sharing the CAN core register port between N_REQ requesters,
// one access per grant, with an optional owner lock released by idle timeout.
module can_reg_arbiter #(
    parameter int N_REQ    = 2,
    parameter int LOCK_MAX = 16
) (
    input  logic               clk_i,
    input  logic               wb_rst_i,
    input  logic [N_REQ-1:0]   req_i,
    input  logic [N_REQ-1:0]   we_i,
    input  logic [N_REQ-1:0]   lock_i,
    input  logic [8*N_REQ-1:0] addr_i,
    input  logic [8*N_REQ-1:0] wdata_i,
    output logic [N_REQ-1:0]   ack_o,
    output logic [8*N_REQ-1:0] rdata_o,
    output logic [N_REQ-1:0]   grant_o,
    output logic               locked_o,
    output logic               reg_rst_o,
    output logic               reg_re_o,
    output logic               reg_we_o,
    output logic [7:0]         reg_addr_o,
    output logic [7:0]         reg_data_in_o,
    input  logic [7:0]         reg_data_out_i
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t           state, state_nxt;
    logic [1:0]       ptr;
    logic [1:0]       owner;
    logic             lat_we;
    logic [7:0]       lock_cnt;

    logic [N_REQ-1:0] cand;
    logic [N_REQ-1:0] win_oh;
    logic [1:0]       win_idx;
    logic             win_found;
    logic             win_we;
    logic [7:0]       win_addr;
    logic [7:0]       win_wdata;
    logic             owner_req;
    logic             owner_lock;
    logic             lock_expire;

    assign reg_rst_o = wb_rst_i;

    // While locked, grant_o is the one-hot owner, so masking by it isolates the owner's bits.
    assign owner_req   = |(req_i & grant_o);
    assign owner_lock  = |(lock_i & grant_o);
    assign lock_expire = locked_o && !owner_req && (lock_cnt == 8'(LOCK_MAX - 1));

    always_comb begin
        cand      = locked_o ? (req_i & grant_o) : req_i;
        win_found = 1'b0;
        win_oh    = '0;
        win_idx   = 2'd0;
        for (int i = 0; i < N_REQ; i++) begin
            for (int j = 0; j < N_REQ; j++) begin
                if (!win_found && cand[j] &&
                    ((int'(ptr) + i == j) || (int'(ptr) + i == j + N_REQ))) begin
                    win_found  = 1'b1;
                    win_oh[j]  = 1'b1;
                    win_idx    = 2'(j);
                end
            end
        end
        win_we    = |(we_i & win_oh);
        win_addr  = 8'h00;
        win_wdata = 8'h00;
        for (int j = 0; j < N_REQ; j++) begin
            if (win_oh[j]) begin
                win_addr  = addr_i[8*j +: 8];
                win_wdata = wdata_i[8*j +: 8];
            end
        end
    end

    always_ff @(posedge clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        reg_re_o  = 1'b0;
        reg_we_o  = 1'b0;
        ack_o     = '0;
        case (state)
            IDLE:  if (win_found) state_nxt = ISSUE;
            ISSUE: begin
                reg_re_o  = !lat_we;
                reg_we_o  = lat_we;
                state_nxt = RESP;
            end
            RESP: begin
                ack_o     = grant_o;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ptr           <= 2'd0;
            owner         <= 2'd0;
            lat_we        <= 1'b0;
            lock_cnt      <= 8'd0;
            grant_o       <= '0;
            locked_o      <= 1'b0;
            rdata_o       <= '0;
            reg_addr_o    <= 8'h00;
            reg_data_in_o <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        grant_o       <= win_oh;
                        owner         <= win_idx;
                        lat_we        <= win_we;
                        reg_addr_o    <= win_addr;
                        reg_data_in_o <= win_wdata;
                        lock_cnt      <= 8'd0;
                    end else if (lock_expire) begin
                        locked_o <= 1'b0;
                        grant_o  <= '0;
                        lock_cnt <= 8'd0;
                    end else if (locked_o) begin
                        lock_cnt <= lock_cnt + 8'd1;
                    end
                end
                ISSUE: begin
                    for (int j = 0; j < N_REQ; j++) begin
                        if (!lat_we && grant_o[j]) rdata_o[8*j +: 8] <= reg_data_out_i;
                    end
                end
                RESP: begin
                    ptr <= (owner == 2'(N_REQ - 1)) ? 2'd0 : owner + 2'd1;
                    if (owner_lock) begin
                        locked_o <= 1'b1;
                    end else begin
                        locked_o <= 1'b0;
                        grant_o  <= '0;
                        lock_cnt <= 8'd0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_can_reg_arbiter.sv
// Directed bench for can_reg_arbiter (3 requesters, LOCK_MAX=4) against a small register ROM.
module tb_can_reg_arbiter;

    localparam int N = 3;

    logic            clk_i = 1'b0;
    logic            wb_rst_i = 1'b1;
    logic [N-1:0]    req_i = '0;
    logic [N-1:0]    we_i = '0;
    logic [N-1:0]    lock_i = '0;
    logic [8*N-1:0]  addr_i = '0;
    logic [8*N-1:0]  wdata_i = '0;
    logic [N-1:0]    ack_o;
    logic [8*N-1:0]  rdata_o;
    logic [N-1:0]    grant_o;
    logic            locked_o;
    logic            reg_rst_o;
    logic            reg_re_o;
    logic            reg_we_o;
    logic [7:0]      reg_addr_o;
    logic [7:0]      reg_data_in_o;
    logic [7:0]      reg_data_out_i;

    int n_tests = 0;
    int n_fail  = 0;
    int wr_count = 0;
    logic [7:0] wr_addr = 8'h00;
    logic [7:0] wr_data = 8'h00;

    can_reg_arbiter #(.N_REQ(N), .LOCK_MAX(4)) dut (
        .clk_i(clk_i), .wb_rst_i(wb_rst_i), .req_i(req_i), .we_i(we_i), .lock_i(lock_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .ack_o(ack_o), .rdata_o(rdata_o),
        .grant_o(grant_o), .locked_o(locked_o), .reg_rst_o(reg_rst_o),
        .reg_re_o(reg_re_o), .reg_we_o(reg_we_o), .reg_addr_o(reg_addr_o),
        .reg_data_in_o(reg_data_in_o), .reg_data_out_i(reg_data_out_i)
    );

    always #5 clk_i = ~clk_i;

    // Register file stand-in: fixed read values, writes recorded for checking.
    always_comb begin
        case (reg_addr_o)
            8'h03:   reg_data_out_i = 8'hA5;
            8'h10:   reg_data_out_i = 8'h11;
            8'h11:   reg_data_out_i = 8'h22;
            8'h12:   reg_data_out_i = 8'h33;
            default: reg_data_out_i = 8'h00;
        endcase
    end

    always @(posedge clk_i) begin
        if (reg_we_o) begin
            wr_count <= wr_count + 1;
            wr_addr  <= reg_addr_o;
            wr_data  <= reg_data_in_o;
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        wb_rst_i = 1'b1;
        tick();
        tick();
        n_tests++; if (reg_rst_o !== 1'b1) begin n_fail++; $display("FAIL rst_passthru_hi got %b want 1", reg_rst_o); end
        n_tests++; if ({ack_o, grant_o, locked_o, reg_re_o, reg_we_o} !== 9'b0) begin n_fail++; $display("FAIL rst_ctrl got %b want 0", {ack_o, grant_o, locked_o, reg_re_o, reg_we_o}); end
        n_tests++; if ({rdata_o, reg_addr_o, reg_data_in_o} !== 40'h0) begin n_fail++; $display("FAIL rst_data got %h want 0", {rdata_o, reg_addr_o, reg_data_in_o}); end
        #2 wb_rst_i = 1'b0;
        #1;
        n_tests++; if (reg_rst_o !== 1'b0) begin n_fail++; $display("FAIL rst_passthru_lo got %b want 0", reg_rst_o); end
        tick();
    endtask

    task automatic test_single_read();
        addr_i[7:0] = 8'h03;
        we_i[0] = 1'b0;
        req_i[0] = 1'b1;
        tick();
        n_tests++; if (grant_o !== 3'b001) begin n_fail++; $display("FAIL rd_grant got %b want 001", grant_o); end
        n_tests++; if ({reg_re_o, reg_we_o} !== 2'b10) begin n_fail++; $display("FAIL rd_strobe got %b want 10", {reg_re_o, reg_we_o}); end
        n_tests++; if (reg_addr_o !== 8'h03) begin n_fail++; $display("FAIL rd_addr got %h want 03", reg_addr_o); end
        n_tests++; if (ack_o !== 3'b000) begin n_fail++; $display("FAIL rd_early_ack got %b want 000", ack_o); end
        tick();
        n_tests++; if (ack_o !== 3'b001) begin n_fail++; $display("FAIL rd_ack got %b want 001", ack_o); end
        n_tests++; if (reg_re_o !== 1'b0) begin n_fail++; $display("FAIL rd_strobe_len got %b want 0", reg_re_o); end
        n_tests++; if (rdata_o[7:0] !== 8'hA5) begin n_fail++; $display("FAIL rd_data got %h want a5", rdata_o[7:0]); end
        req_i[0] = 1'b0;
        tick();
        n_tests++; if ({ack_o, grant_o} !== 6'b0) begin n_fail++; $display("FAIL rd_idle got %b want 0", {ack_o, grant_o}); end
        n_tests++; if (reg_addr_o !== 8'h03) begin n_fail++; $display("FAIL rd_addr_hold got %h want 03", reg_addr_o); end
    endtask

    task automatic test_write();
        addr_i[15:8]  = 8'h1F;
        wdata_i[15:8] = 8'h5C;
        we_i[1]  = 1'b1;
        req_i[1] = 1'b1;
        tick();
        n_tests++; if (grant_o !== 3'b010) begin n_fail++; $display("FAIL wr_grant got %b want 010", grant_o); end
        n_tests++; if ({reg_re_o, reg_we_o} !== 2'b01) begin n_fail++; $display("FAIL wr_strobe got %b want 01", {reg_re_o, reg_we_o}); end
        n_tests++; if ({reg_addr_o, reg_data_in_o} !== 16'h1F5C) begin n_fail++; $display("FAIL wr_bus got %h want 1f5c", {reg_addr_o, reg_data_in_o}); end
        tick();
        n_tests++; if (ack_o !== 3'b010) begin n_fail++; $display("FAIL wr_ack got %b want 010", ack_o); end
        n_tests++; if (rdata_o[15:0] !== 16'h00A5) begin n_fail++; $display("FAIL wr_rdata_kept got %h want 00a5", rdata_o[15:0]); end
        n_tests++; if ({wr_count, wr_addr, wr_data} !== {32'd1, 16'h1F5C}) begin n_fail++; $display("FAIL wr_reg got %0d/%h/%h want 1/1f/5c", wr_count, wr_addr, wr_data); end
        req_i[1] = 1'b0;
        we_i[1]  = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] exp_g;
        // Reset first so the round-robin pointer starts at requester 0.
        #2 wb_rst_i = 1'b1;
        #2 wb_rst_i = 1'b0;
        tick();
        addr_i = 24'h12_11_10;
        we_i   = '0;
        req_i  = 3'b111;
        for (int n = 0; n < 9; n++) begin
            exp_g = 3'(1 << (n % 3));
            tick();
            n_tests++; if (grant_o !== exp_g || reg_re_o !== 1'b1) begin n_fail++; $display("FAIL rr_grant[%0d] got %b/%b want %b/1", n, grant_o, reg_re_o, exp_g); end
            n_tests++; if (reg_addr_o !== 8'(8'h10 + n % 3)) begin n_fail++; $display("FAIL rr_addr[%0d] got %h want %h", n, reg_addr_o, 8'(8'h10 + n % 3)); end
            tick();
            n_tests++; if (ack_o !== exp_g || reg_re_o !== 1'b0) begin n_fail++; $display("FAIL rr_ack[%0d] got %b/%b want %b/0", n, ack_o, reg_re_o, exp_g); end
            if (n == 8) req_i = '0;
            tick();
            n_tests++; if ({ack_o, grant_o, reg_re_o} !== 7'b0) begin n_fail++; $display("FAIL rr_idle[%0d] got %b want 0", n, {ack_o, grant_o, reg_re_o}); end
        end
        n_tests++; if (rdata_o !== 24'h33_22_11) begin n_fail++; $display("FAIL rr_rdata got %h want 332211", rdata_o); end
    endtask

    task automatic test_lock();
        addr_i   = 24'h00_11_10;
        we_i     = '0;
        lock_i   = 3'b010;
        req_i    = 3'b010;
        for (int n = 0; n < 3; n++) begin
            if (n == 2) lock_i[1] = 1'b0;
            tick();
            n_tests++; if (grant_o !== 3'b010 || reg_re_o !== 1'b1) begin n_fail++; $display("FAIL lk_grant[%0d] got %b/%b want 010/1", n, grant_o, reg_re_o); end
            if (n == 0) req_i[0] = 1'b1;
            tick();
            n_tests++; if (ack_o !== 3'b010) begin n_fail++; $display("FAIL lk_ack[%0d] got %b want 010", n, ack_o); end
            if (n == 2) req_i[1] = 1'b0;
            tick();
            n_tests++; if (locked_o !== (n < 2)) begin n_fail++; $display("FAIL lk_locked[%0d] got %b want %b", n, locked_o, n < 2); end
            n_tests++; if (grant_o !== ((n < 2) ? 3'b010 : 3'b000)) begin n_fail++; $display("FAIL lk_hold[%0d] got %b", n, grant_o); end
        end
        tick();
        n_tests++; if (grant_o !== 3'b001 || reg_addr_o !== 8'h10) begin n_fail++; $display("FAIL lk_next got %b/%h want 001/10", grant_o, reg_addr_o); end
        tick();
        n_tests++; if (ack_o !== 3'b001 || rdata_o[15:0] !== 16'h2211) begin n_fail++; $display("FAIL lk_next_ack got %b/%h want 001/2211", ack_o, rdata_o[15:0]); end
        req_i = '0;
        tick();
    endtask

    task automatic test_lock_timeout();
        addr_i = 24'h00_11_03;
        we_i   = '0;
        lock_i = 3'b001;
        req_i  = 3'b001;
        tick();
        n_tests++; if (grant_o !== 3'b001) begin n_fail++; $display("FAIL to_grant got %b want 001", grant_o); end
        req_i[1] = 1'b1;
        tick();
        req_i[0] = 1'b0;
        tick();
        lock_i = '0;
        n_tests++; if (locked_o !== 1'b1 || grant_o !== 3'b001) begin n_fail++; $display("FAIL to_locked got %b/%b want 1/001", locked_o, grant_o); end
        for (int c = 1; c <= 3; c++) begin
            tick();
            n_tests++; if (locked_o !== 1'b1 || grant_o !== 3'b001 || reg_re_o !== 1'b0) begin n_fail++; $display("FAIL to_wait[%0d] got %b/%b/%b want 1/001/0", c, locked_o, grant_o, reg_re_o); end
        end
        tick();
        n_tests++; if (locked_o !== 1'b0 || grant_o !== 3'b000) begin n_fail++; $display("FAIL to_release got %b/%b want 0/000", locked_o, grant_o); end
        tick();
        n_tests++; if (grant_o !== 3'b010 || reg_re_o !== 1'b1 || reg_addr_o !== 8'h11) begin n_fail++; $display("FAIL to_other got %b/%b/%h want 010/1/11", grant_o, reg_re_o, reg_addr_o); end
        tick();
        n_tests++; if (ack_o !== 3'b010) begin n_fail++; $display("FAIL to_ack got %b want 010", ack_o); end
        req_i = '0;
        tick();
    endtask

    task automatic test_reset_mid();
        int wc;
        addr_i  = 24'h40_00_00;
        wdata_i = 24'h77_00_00;
        we_i    = 3'b100;
        req_i   = 3'b100;
        tick();
        n_tests++; if (reg_we_o !== 1'b1 || grant_o !== 3'b100) begin n_fail++; $display("FAIL rm_issue got %b/%b want 1/100", reg_we_o, grant_o); end
        wc = wr_count;
        #2 wb_rst_i = 1'b1;
        #1;
        n_tests++; if ({reg_re_o, reg_we_o, ack_o, grant_o, locked_o} !== 9'b0) begin n_fail++; $display("FAIL rm_ctrl got %b want 0", {reg_re_o, reg_we_o, ack_o, grant_o, locked_o}); end
        n_tests++; if ({rdata_o, reg_addr_o, reg_data_in_o} !== 40'h0) begin n_fail++; $display("FAIL rm_data got %h want 0", {rdata_o, reg_addr_o, reg_data_in_o}); end
        req_i = '0;
        we_i  = '0;
        tick();
        n_tests++; if (ack_o !== 3'b000 || wr_count !== wc) begin n_fail++; $display("FAIL rm_noack got %b/%0d want 000/%0d", ack_o, wr_count, wc); end
        wb_rst_i = 1'b0;
        addr_i = 24'h12_00_00;
        req_i  = 3'b100;
        tick();
        n_tests++; if (grant_o !== 3'b100 || reg_re_o !== 1'b1 || reg_addr_o !== 8'h12) begin n_fail++; $display("FAIL rm_after got %b/%b/%h want 100/1/12", grant_o, reg_re_o, reg_addr_o); end
        tick();
        n_tests++; if (ack_o !== 3'b100 || rdata_o !== 24'h33_00_00) begin n_fail++; $display("FAIL rm_after_ack got %b/%h want 100/330000", ack_o, rdata_o); end
        req_i = '0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_write();
        test_back_to_back();
        test_lock();
        test_lock_timeout();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/can_reg_arbiter.md
# can_reg_arbiter

Round-robin arbiter that shares the CAN core's single register port between up to four requesters on the core clock domain, e.g. the Wishbone bridge, an RX-buffer drain engine and a configuration sequencer. Each requester gets one register access per grant through a req/ack handshake. Read data is captured and returned per requester. An optional lock lets one requester run an uninterrupted multi-access sequence, for example a read of the interrupt register followed by a receive-buffer release.

## Interface
- N_REQ, 2: number of requesters; legal range 2..4.
- LOCK_MAX, 16: idle cycles a locked owner may go without a request before the lock is force-released; legal range 1..255.

- clk_i  in  1  core clock; all logic is on its rising edge.
- wb_rst_i  in  1  reset, asynchronous, active-high.
- req_i  in  N_REQ  per-requester access request; level signal.
- we_i  in  N_REQ  per-requester direction; 1 = write, 0 = read.
- lock_i  in  N_REQ  per-requester lock request; sampled in the owner's ack cycle.
- addr_i  in  8*N_REQ  per-requester register address; requester k uses bits [8k+7:8k].
- wdata_i  in  8*N_REQ  per-requester write data, same packing as addr_i.
- ack_o  out  N_REQ  one-cycle completion pulse to the owner.
- rdata_o  out  8*N_REQ  per-requester read data, same packing.
- grant_o  out  N_REQ  one-hot current owner; all zero when idle and unlocked.
- locked_o  out  1  lock currently held.
- reg_rst_o  out  1  wb_rst_i passed through combinationally.
- reg_re_o  out  1  register read strobe.
- reg_we_o  out  1  register write strobe.
- reg_addr_o  out  8  register address.
- reg_data_in_o  out  8  register write data.
- reg_data_out_i  in  8  register read data; combinational from reg_addr_o and valid in the same cycle.

## Operation
- FSM states: IDLE, ISSUE, RESP.
- IDLE
  - Candidates are every k with req_i[k]=1. While locked, the only candidate is the owner.
  - Winner is the first candidate found searching upward from the round-robin pointer, wrapping from N_REQ-1 to 0.
  - Latch the winner's we_i, addr_i and wdata_i; set grant_o; go to ISSUE.
  - With no candidate, stay in IDLE.
- ISSUE
  - Drive reg_addr_o and reg_data_in_o from the latched values.
  - Assert reg_re_o (read) or reg_we_o (write) for exactly this cycle.
  - On a read, capture reg_data_out_i into the owner's rdata_o slot.
  - Always go to RESP.
- RESP
  - Pulse ack_o[owner].
  - Set the pointer to owner+1 mod N_REQ.
  - If lock_i[owner]=1: set locked_o and keep grant_o. Otherwise clear locked_o and grant_o.
  - Go to IDLE.
- Requester rules
  - addr_i, we_i and wdata_i must be held stable from req_i rising until the ack cycle.
  - req_i still high in the cycle after ack is treated as a new request.
  - Dropping req_i before ack is a protocol violation; the latched access still completes and acks.
- rdata_o[k] changes only when requester k's read is issued. It holds between accesses and is not touched by writes.
- Lock timeout
  - While locked and in IDLE with req_i[owner]=0, an 8-bit counter increments each cycle.
  - When the counter reaches LOCK_MAX, clear locked_o and grant_o. Other requesters are eligible in the next cycle.
  - The counter clears on every grant and on lock release.
- Any number of simultaneous requests is legal; exactly one is served per arbitration.
- Reg-port outputs hold their last values when idle. Only the strobes return to 0.

## Timing
- Reset values: ack_o=0, rdata_o=0, grant_o=0, locked_o=0, reg_re_o=0, reg_we_o=0, reg_addr_o=0x00, reg_data_in_o=0x00; FSM=IDLE, pointer=0, timeout counter=0.
- Latency, with req_i rising before edge T0:
  - grant_o valid after T0.
  - Strobe high in cycle T0..T1.
  - ack_o high in cycle T1..T2.
  - rdata_o valid from the ack cycle onward.
- Throughput: one access per 3 cycles, back-to-back with no dead cycle.
- Reset mid-operation: all state clears asynchronously and the strobes drop immediately. The interrupted access gets no ack. Requesters must reissue after reset.
- reg_rst_o follows wb_rst_i with zero latency.

## Test plan
- Single read: req_i[0] with addr 0x03 while the register model returns 0xA5 -> reg_re_o for one cycle with reg_addr_o=0x03; ack_o[0] one cycle later; rdata_o[7:0]=0xA5.
- Write: requester 1 writes 0x5C to 0x1F -> reg_we_o for one cycle with reg_data_in_o=0x5C; ack_o[1]; rdata_o[15:8] unchanged.
- Fairness: N_REQ=3 with all req_i held high for 9 accesses -> grant order 0,1,2,0,1,2,0,1,2; strobes every 3 cycles.
- Lock: requester 1 locks for 3 reads while requester 0 requests continuously -> three consecutive grants to 1; after the unlocked ack, requester 0 is granted next.
- Lock timeout: LOCK_MAX=4, owner 0 locks then drops req_i while requester 1 requests -> locked_o clears after 4 idle cycles; requester 1 strobes 1 cycle later.
- Reset mid-access: assert wb_rst_i during ISSUE -> reg_re_o/reg_we_o drop immediately; no ack_o; all outputs at reset values; a normal access works after release.
